// File: rtl/vec_pkg.sv
// Shared definitions for the vector ALU issue path: FSM states, element-width
// encodings and the legality check used at issue time.
package vec_pkg;

    localparam int OPCODE_W     = 6;
    localparam int VSEW_W       = 3;
    localparam int VLEN_DEFAULT = 128;

    localparam logic [VSEW_W-1:0] VSEW_8  = 3'b000;
    localparam logic [VSEW_W-1:0] VSEW_16 = 3'b001;
    localparam logic [VSEW_W-1:0] VSEW_32 = 3'b010;
    localparam logic [VSEW_W-1:0] VSEW_64 = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CLEAR,
        ST_RUN,
        ST_WB
    } seq_state_e;

    function automatic logic vsew_legal(input logic [VSEW_W-1:0] vsew);
        return (vsew == VSEW_8) || (vsew == VSEW_16) ||
               (vsew == VSEW_32) || (vsew == VSEW_64);
    endfunction

endpackage

// File: rtl/vec_alu_seq.sv
// Issue-side sequencer for vec_alu: reads two operands, runs the ALU through a
// clear/run handshake, and writes the result back to the vector register file.
module vec_alu_seq
    import vec_pkg::*;
#(
    parameter int VLEN    = VLEN_DEFAULT,
    parameter int RADDR_W = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [OPCODE_W-1:0] issue_opcode,
    input  logic [VSEW_W-1:0]   issue_vsew,
    input  logic [RADDR_W-1:0]  issue_vs1,
    input  logic [RADDR_W-1:0]  issue_vs2,
    input  logic [RADDR_W-1:0]  issue_vd,
    output logic [RADDR_W-1:0]  rf_raddr1,
    output logic [RADDR_W-1:0]  rf_raddr2,
    input  logic [VLEN-1:0]     rf_rdata1,
    input  logic [VLEN-1:0]     rf_rdata2,
    output logic                rf_we,
    output logic [RADDR_W-1:0]  rf_waddr,
    output logic [VLEN-1:0]     rf_wdata,
    output logic [OPCODE_W-1:0] alu_opcode,
    output logic [VSEW_W-1:0]   alu_vsew,
    output logic [VLEN-1:0]     alu_vs1,
    output logic [VLEN-1:0]     alu_vs2,
    output logic                alu_run,
    input  logic [VLEN-1:0]     alu_vd,
    input  logic                alu_done,
    output logic                busy,
    output logic                err_vsew,
    output logic                err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_e          state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [VSEW_W-1:0]   vsew_q, vsew_d;
    logic [RADDR_W-1:0]  vs1_q, vs1_d;
    logic [RADDR_W-1:0]  vs2_q, vs2_d;
    logic [RADDR_W-1:0]  vd_q, vd_d;
    logic [VLEN-1:0]     alu_vs1_q, alu_vs1_d;
    logic [VLEN-1:0]     alu_vs2_q, alu_vs2_d;
    logic [VLEN-1:0]     rf_wdata_q, rf_wdata_d;
    logic                alu_run_q, alu_run_d;
    logic                rf_we_q, rf_we_d;
    logic                err_vsew_q, err_vsew_d;
    logic                err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // The register file reads synchronously, so the address must reach it on
    // the accepting edge; afterwards the latched numbers hold it through READ.
    assign rf_raddr1   = (state_q == ST_IDLE) ? issue_vs1 : vs1_q;
    assign rf_raddr2   = (state_q == ST_IDLE) ? issue_vs2 : vs2_q;

    assign issue_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rf_we       = rf_we_q;
    assign rf_waddr    = vd_q;
    assign rf_wdata    = rf_wdata_q;
    assign alu_opcode  = opcode_q;
    assign alu_vsew    = vsew_q;
    assign alu_vs1     = alu_vs1_q;
    assign alu_vs2     = alu_vs2_q;
    assign alu_run     = alu_run_q;
    assign err_vsew    = err_vsew_q;
    assign err_timeout = err_timeout_q;

    always_comb begin
        // NOTE: every _d defaults to its _q (or to 0 for pulses) before the case,
        // so no path through the case can infer a latch.
        state_d       = state_q;
        opcode_d      = opcode_q;
        vsew_d        = vsew_q;
        vs1_d         = vs1_q;
        vs2_d         = vs2_q;
        vd_d          = vd_q;
        alu_vs1_d     = alu_vs1_q;
        alu_vs2_d     = alu_vs2_q;
        rf_wdata_d    = rf_wdata_q;
        alu_run_d     = alu_run_q;
        cnt_d         = cnt_q;
        rf_we_d       = 1'b0;
        err_vsew_d    = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (issue_valid) begin
                    opcode_d = issue_opcode;
                    vsew_d   = issue_vsew;
                    vs1_d    = issue_vs1;
                    vs2_d    = issue_vs2;
                    vd_d     = issue_vd;
                    if (vsew_legal(issue_vsew)) begin
                        state_d = ST_READ;
                    end else begin
                        err_vsew_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                alu_vs1_d = rf_rdata1;
                alu_vs2_d = rf_rdata2;
                state_d   = ST_CLEAR;
            end
            ST_CLEAR: begin
                // alu_done is stale here; run is low this cycle so the ALU restarts.
                cnt_d     = '0;
                alu_run_d = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (alu_done) begin
                    rf_wdata_d = alu_vd;
                    rf_we_d    = 1'b1;
                    state_d    = ST_WB;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    alu_run_d     = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_WB: begin
                alu_run_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            opcode_q      <= '0;
            vsew_q        <= '0;
            vs1_q         <= '0;
            vs2_q         <= '0;
            vd_q          <= '0;
            alu_vs1_q     <= '0;
            alu_vs2_q     <= '0;
            rf_wdata_q    <= '0;
            alu_run_q     <= 1'b0;
            rf_we_q       <= 1'b0;
            err_vsew_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            vsew_q        <= vsew_d;
            vs1_q         <= vs1_d;
            vs2_q         <= vs2_d;
            vd_q          <= vd_d;
            alu_vs1_q     <= alu_vs1_d;
            alu_vs2_q     <= alu_vs2_d;
            rf_wdata_q    <= rf_wdata_d;
            alu_run_q     <= alu_run_d;
            rf_we_q       <= rf_we_d;
            err_vsew_q    <= err_vsew_d;
            err_timeout_q <= err_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule
